clock_step_ctrl: RTL and testbench
==================================

Name: clock_step_ctrl

Overview:
- Synchronous run/pause/single-step controller for the CPU. Replaces gated-clock control with a one-cycle clock-enable strobe in the board clock domain.
- Consumes raw pushbuttons, the divided tick from CLOCK_DIV, and a halt request from the CPU core. Drives the CPU's clock enable and reports run state and a retired-cycle count back to the display logic.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: cycles a synchronized button level must hold stable before it is accepted.
- STEP_BURST, 8'd1: number of clk_en pulses issued per step press in tick mode; 0 is treated as 1.
- COUNT_W, 32: width of cycle_count.

Ports:
- clk_in  input  1  board clock; all logic is on its rising edge.
- reset  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle strobe from CLOCK_DIV; paces RUN and STEP.
- start_button  input  1  raw pushbutton, active-low, asynchronous.
- step_button  input  1  raw pushbutton, active-low, asynchronous.
- manual_clock  input  1  level; 1 selects manual single-cycle mode.
- halt_req  input  1  level from the CPU, e.g. a break instruction.
- clk_en  output  1  one-cycle CPU clock-enable strobe.
- running  output  1  state is RUN.
- halted  output  1  state is HALTED.
- cycle_count  output  COUNT_W  number of clk_en pulses issued.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, clk_en=0, running=0, halted=0, cycle_count=0, burst counter=0, debouncers at released level (1).
- Button path, per button:
  - 2-FF synchronizer, then a stability counter.
  - The accepted level updates when the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse on the accepted 1->0 edge. Releases generate no event.
- FSM states: IDLE, RUN, STEP, HALTED. Per-cycle priority: halt_req > manual_clock > start press > step press.
- IDLE:
  - start press with manual_clock=0 -> RUN.
  - step press with manual_clock=0 -> STEP; burst counter loads max(STEP_BURST,1).
  - step press with manual_clock=1 -> stay IDLE and issue exactly one clk_en the next cycle, no tick wait.
  - start press with manual_clock=1 is ignored.
- RUN: start press -> IDLE; manual_clock=1 -> IDLE; halt_req=1 -> HALTED. Step presses are ignored.
- STEP:
  - Each tick decrements the burst counter.
  - The tick that takes the counter from 1 to 0 -> IDLE.
  - start press aborts to IDLE. manual_clock=1 -> IDLE. halt_req=1 -> HALTED.
- HALTED:
  - clk_en is held 0.
  - start press with halt_req=0 -> IDLE.
  - start press while halt_req=1 stays HALTED.
  - Step presses are ignored.
- clk_en is registered. It is 1 in cycle N+1 iff one of these holds:
  - state in cycle N is RUN or STEP, tick=1 in cycle N, and no halt_req or manual_clock in cycle N;
  - a manual step press event occurred in cycle N.
- Consequences: clk_en is never high on two consecutive cycles unless tick is. A tick arriving in the same cycle as the exit transition produces no pulse.
- cycle_count increments by 1 in the cycle after each clk_en=1 and wraps modulo 2^COUNT_W.
- running and halted are registered state decodes with 0-cycle lag from the state register.
- Reset asserted mid-RUN or mid-STEP: clk_en drops immediately and the burst is discarded.

Decomposition:
- Shared package clock_ctrl_pkg holds:
  - the state enum {IDLE, RUN, STEP, HALTED} with 2-bit encoding 0..3;
  - the default DEBOUNCE_CYCLES constant, shared with other button users.
- Sub-module: button_debounce (synchronizer, stability counter, press-event pulse), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, STEP_BURST=3, tick every 5th cycle):
- Reset, then hold start_button low for 10 cycles -> RUN within 2+4+1 cycles. Then 10 ticks -> 10 clk_en pulses, each 1 cycle after its tick; cycle_count=10.
- From IDLE, a step press -> exactly 3 clk_en pulses on the next 3 ticks, then IDLE; cycle_count +3; a 4th tick gives no pulse.
- In RUN, assert halt_req together with a tick -> no clk_en, halted=1, running=0. Start press while halt_req=1 -> stays HALTED. Drop halt_req, press start -> IDLE.
- manual_clock=1, five step presses -> five single clk_en pulses, none aligned to tick. Start presses are ignored; cycle_count=5.
- Bounce start_button (low 2, high 1, low 2 cycles) -> no press event. Then a stable low for 4 cycles -> exactly one event.
- Assert reset mid-STEP with 2 pulses remaining -> clk_en=0 at once, state=IDLE, cycle_count=0. After release, ticks produce no pulses.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the CPU run/pause/single-step controller
// and any other block that debounces board pushbuttons.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } ctrl_state_e;

  localparam logic [15:0] DEBOUNCE_CYCLES_DEFAULT = 16'd50000;

  // A burst length of zero would leave STEP with nothing to count down.
  function automatic logic [7:0] burst_load(input logic [7:0] burst);
    return (burst == 8'd0) ? 8'd1 : burst;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low pushbutton conditioner: 2-FF synchronizer, stability counter and
// a one-cycle pulse when the accepted level falls (press). Releases are silent.
module button_debounce
  import clock_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_n_i,
  output logic press_o
);

  localparam logic [15:0] THRESH = (DEBOUNCE_CYCLES == 16'd0) ? 16'd1 : DEBOUNCE_CYCLES;

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic [15:0] cnt_q, cnt_d;

  // Synchronizer and accepted level come out of reset at the released level.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      sync1_q <= button_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = 16'd0;
    if (sync2_q != level_q) begin
      if (cnt_q == THRESH - 16'd1) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_step_ctrl.sv
// Run/pause/single-step controller: turns debounced buttons, the divided tick
// and the core's halt request into a one-cycle CPU clock-enable strobe.
module clock_step_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic [7:0]  STEP_BURST      = 8'd1,
  parameter int unsigned COUNT_W         = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick,
  input  logic               start_button,
  input  logic               step_button,
  input  logic               manual_clock,
  input  logic               halt_req,
  output logic               clk_en,
  output logic               running,
  output logic               halted,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e        state_q, state_d;
  logic [7:0]         burst_q, burst_d;
  logic               clk_en_q, clk_en_d;
  logic               running_q, halted_q;
  logic [COUNT_W-1:0] cycle_count_q;
  logic               start_press, step_press;
  logic               tick_ok;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk        (clk_in),
    .rst_n      (reset),
    .button_n_i (start_button),
    .press_o    (start_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk        (clk_in),
    .rst_n      (reset),
    .button_n_i (step_button),
    .press_o    (step_press)
  );

  // A tick only paces the core when neither halt nor manual mode overrides it.
  assign tick_ok = tick && !halt_req && !manual_clock;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      burst_q       <= 8'd0;
      clk_en_q      <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      clk_en_q  <= clk_en_d;
      running_q <= (state_d == RUN);
      halted_q  <= (state_d == HALTED);
      if (clk_en_q) begin
        cycle_count_q <= cycle_count_q + COUNT_ONE;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    clk_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!manual_clock) begin
          if (start_press) begin
            state_d = RUN;
          end else if (step_press) begin
            state_d = STEP;
            burst_d = burst_load(STEP_BURST);
          end
        end else if (step_press) begin
          // Manual single cycle: fire on the next cycle without waiting for tick.
          clk_en_d = 1'b1;
        end
      end
      RUN: begin
        clk_en_d = tick_ok;
        if (halt_req) begin
          state_d = HALTED;
        end else if (manual_clock || start_press) begin
          state_d = IDLE;
        end
      end
      STEP: begin
        clk_en_d = tick_ok;
        if (halt_req) begin
          state_d = HALTED;
          burst_d = 8'd0;
        end else if (manual_clock || start_press) begin
          state_d = IDLE;
          burst_d = 8'd0;
        end else if (tick) begin
          burst_d = burst_q - 8'd1;
          if (burst_q <= 8'd1) begin
            state_d = IDLE;
          end
        end
      end
      HALTED: begin
        if (start_press && !halt_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clk_en      = clk_en_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: directed scenarios followed by a random phase,
// every cycle compared with a history-based behavioural model.
module tb_clock_step_ctrl;

  localparam logic [15:0] DEB   = 16'd4;
  localparam logic [7:0]  BURST = 8'd3;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        start_button = 1'b1;
  logic        step_button = 1'b1;
  logic        manual_clock = 1'b0;
  logic        halt_req = 1'b0;
  logic        clk_en, running, halted;
  logic [31:0] cycle_count;

  clock_step_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .STEP_BURST      (BURST),
    .COUNT_W         (32)
  ) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .tick         (tick),
    .start_button (start_button),
    .step_button  (step_button),
    .manual_clock (manual_clock),
    .halt_req     (halt_req),
    .clk_en       (clk_en),
    .running      (running),
    .halted       (halted),
    .cycle_count  (cycle_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model state. Button histories are indexed by clock edge number.
  int          m_state;
  int          m_burst;
  bit          m_clk_en;
  logic [31:0] m_count;
  bit          st_h [0:8191];
  bit          sp_h [0:8191];
  int          e = 0;
  int          rst_e = 0;
  int          phase = 0;
  bit          rand_mode = 1'b0;
  bit          acc_st, acc_sp;
  int          last_st, last_sp;
  bit          pend_st, pend_sp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw level that was driven before edge k; before reset release it reads as released.
  function automatic bit samp(input bit which, input int k);
    if (k < rst_e) return 1'b1;
    return which ? sp_h[k] : st_h[k];
  endfunction

  // The accepted level changes at edge e when the synchronized samples seen at the
  // last DEB edges (raw levels two edges older) all differ from it, and at least
  // DEB edges have passed since its previous change.
  function automatic bit settled(input bit which, input bit acc, input int last);
    if (e - last < int'(DEB)) return 1'b0;
    for (int j = 0; j < int'(DEB); j++) begin
      if (samp(which, e - 2 - j) == acc) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_burst  = 0;
    m_clk_en = 1'b0;
    m_count  = 32'd0;
    acc_st   = 1'b1;
    acc_sp   = 1'b1;
    pend_st  = 1'b0;
    pend_sp  = 1'b0;
  endtask

  task automatic model_release();
    rst_e   = e;
    last_st = e - 1;
    last_sp = e - 1;
  endtask

  task automatic model_step();
    bit sp, stp, pulse;
    st_h[e] = start_button;
    sp_h[e] = step_button;
    sp  = pend_st;
    stp = pend_sp;
    pend_st = 1'b0;
    pend_sp = 1'b0;
    if (settled(1'b0, acc_st, last_st)) begin
      acc_st  = !acc_st;
      last_st = e;
      pend_st = !acc_st;
    end
    if (settled(1'b1, acc_sp, last_sp)) begin
      acc_sp  = !acc_sp;
      last_sp = e;
      pend_sp = !acc_sp;
    end
    pulse = ((m_state == M_RUN || m_state == M_STEP) && tick && !halt_req && !manual_clock)
         || (m_state == M_IDLE && manual_clock && stp);
    case (m_state)
      M_IDLE: begin
        if (!manual_clock) begin
          if (sp) m_state = M_RUN;
          else if (stp) begin
            m_state = M_STEP;
            m_burst = (BURST == 8'd0) ? 1 : int'(BURST);
          end
        end
      end
      M_RUN, M_STEP: begin
        if (halt_req) m_state = M_HALT;
        else if (manual_clock || sp) m_state = M_IDLE;
        else if (m_state == M_STEP && tick) begin
          m_burst = m_burst - 1;
          if (m_burst == 0) m_state = M_IDLE;
        end
      end
      default: begin
        if (sp && !halt_req) m_state = M_IDLE;
      end
    endcase
    m_count  = m_count + 32'(m_clk_en);
    m_clk_en = pulse;
  endtask

  // One clock: drive tick, advance the model, sample 1 ns after the edge, return at negedge.
  task automatic cycle();
    tick = rand_mode ? ($urandom_range(0, 3) == 0) : (phase % 5 == 4);
    model_step();
    @(posedge clk_in);
    #1;
    check("clk_en", 32'(clk_en), 32'(m_clk_en));
    check("running", 32'(running), 32'(m_state == M_RUN));
    check("halted", 32'(halted), 32'(m_state == M_HALT));
    check("cycle_count", cycle_count, m_count);
    e++;
    phase++;
    @(negedge clk_in);
  endtask

  task automatic press(input bit which, input int low_n, input int high_n);
    if (which) step_button = 1'b0; else start_button = 1'b0;
    repeat (low_n) cycle();
    if (which) step_button = 1'b1; else start_button = 1'b1;
    repeat (high_n) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c0;
    int          lat;
    int          n;
    bit          found;
    int          sl, pl, hl, ml;

    model_reset();
    repeat (2) begin
      @(posedge clk_in);
      e++;
    end
    @(negedge clk_in);
    check("reset_clk_en", 32'(clk_en), 32'(m_clk_en));
    check("reset_running", 32'(running), 32'(m_state == M_RUN));
    check("reset_halted", 32'(halted), 32'(m_state == M_HALT));
    check("reset_count", cycle_count, m_count);
    reset = 1'b1;
    model_release();

    // Start held low for 10 cycles enters RUN, then ten ticks give ten pulses.
    start_button = 1'b0;
    lat = -1;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) start_button = 1'b1;
      if (m_state == M_RUN && phase % 5 == 4) n++;
      cycle();
      if (running && lat < 0) lat = i + 1;
      if (n == 10) break;
    end
    start_button = 1'b1;
    check("run_latency_within_7", 32'(lat > 0 && lat <= 7), 32'd1);
    check("run_ticks_seen", 32'(n), 32'd10);
    cycle();
    check("run_count_10", cycle_count, 32'd10);
    press(1'b0, 8, 8);
    check("run_stopped", 32'(running), 32'd0);

    // Step burst: three pulses on three ticks, later ticks are silent.
    c0 = cycle_count;
    press(1'b1, 8, 8);
    repeat (20) cycle();
    check("step_burst_delta", cycle_count - c0, 32'd3);
    check("step_back_idle", 32'(running | halted), 32'd0);

    // Halt arriving with a tick suppresses the pulse; start cannot leave while halt holds.
    press(1'b0, 8, 8);
    for (int k = 0; k < 5 && phase % 5 != 4; k++) cycle();
    halt_req = 1'b1;
    cycle();
    check("halt_no_pulse", 32'(clk_en), 32'd0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_not_running", 32'(running), 32'd0);
    press(1'b0, 8, 8);
    check("halt_held", 32'(halted), 32'd1);
    halt_req = 1'b0;
    cycle();
    press(1'b0, 8, 8);
    check("halt_released", 32'(halted | running), 32'd0);

    // Manual mode: each step press gives one pulse, start presses do nothing.
    manual_clock = 1'b1;
    c0 = cycle_count;
    repeat (5) press(1'b1, 8, 8);
    press(1'b0, 8, 8);
    check("manual_delta", cycle_count - c0, 32'd5);
    check("manual_not_running", 32'(running), 32'd0);
    manual_clock = 1'b0;
    cycle();

    // Bounce shorter than the stability window is ignored; a clean 4-cycle low is accepted.
    press(1'b0, 2, 1);
    press(1'b0, 2, 8);
    check("bounce_ignored", 32'(running), 32'd0);
    press(1'b0, 4, 10);
    check("stable_press_run", 32'(running), 32'd1);
    press(1'b0, 8, 8);
    check("stable_press_stop", 32'(running), 32'd0);

    // Reset in the middle of a step burst, right while a pulse is high.
    step_button = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 8) step_button = 1'b1;
      cycle();
      if (clk_en) begin
        found = 1'b1;
        break;
      end
    end
    step_button = 1'b1;
    check("step_first_pulse_seen", 32'(found), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check("midstep_rst_clk_en", 32'(clk_en), 32'(m_clk_en));
    check("midstep_rst_running", 32'(running), 32'd0);
    check("midstep_rst_count", cycle_count, m_count);
    repeat (2) begin
      @(posedge clk_in);
      e++;
    end
    @(negedge clk_in);
    reset = 1'b1;
    model_release();
    repeat (30) cycle();
    check("post_reset_no_pulses", cycle_count, 32'd0);

    // Random phase: buttons, halt and manual mode held for random spans, random ticks.
    rand_mode = 1'b1;
    sl = 0; pl = 0; hl = 0; ml = 0;
    repeat (800) begin
      if (sl == 0) begin
        start_button = 1'($urandom_range(0, 1));
        sl = int'($urandom_range(1, 12));
      end
      if (pl == 0) begin
        step_button = 1'($urandom_range(0, 1));
        pl = int'($urandom_range(1, 12));
      end
      if (hl == 0) begin
        halt_req = ($urandom_range(0, 5) == 0);
        hl = int'($urandom_range(1, 20));
      end
      if (ml == 0) begin
        manual_clock = ($urandom_range(0, 3) == 0);
        ml = int'($urandom_range(5, 40));
      end
      sl--; pl--; hl--; ml--;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
